// File: rtl/sid_reg_if.sv
// Register-write responder for the SID host bus: synchronises the write strobe,
// decodes voice/address, holds all voice and filter registers, and emits write/gate events.
module sid_reg_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_strobe,
    input  logic [1:0]  wr_voice,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [47:0] freq,
    output logic [35:0] pw,
    output logic [23:0] atk,
    output logic [23:0] sus,
    output logic [23:0] wav,
    output logic [10:0] fc,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol,
    output logic        wr_event,
    output logic [2:0]  gate_on,
    output logic [2:0]  gate_off
);

    localparam logic [1:0] FILTER_VOICE = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   w_commit;

    logic [15:0] r_freq [0:2];
    logic [11:0] r_pw   [0:2];
    logic [7:0]  r_atk  [0:2];
    logic [7:0]  r_sus  [0:2];
    logic [7:0]  r_wav  [0:2];
    logic [10:0] r_fc;
    logic [7:0]  r_res_filt;
    logic [7:0]  r_mode_vol;
    logic        r_wr_event;
    logic [2:0]  r_gate_on;
    logic [2:0]  r_gate_off;

    // Strobe flops reset high so a strobe already high at reset release looks like no edge.
    assign w_commit = r_sync[SYNC_STAGES-1] & ~r_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '1;
            r_edge     <= 1'b1;
            r_fc       <= '0;
            r_res_filt <= '0;
            r_mode_vol <= '0;
            r_wr_event <= 1'b0;
            r_gate_on  <= '0;
            r_gate_off <= '0;
            for (int i = 0; i < 3; i++) begin
                r_freq[i] <= '0;
                r_pw[i]   <= '0;
                r_atk[i]  <= '0;
                r_sus[i]  <= '0;
                r_wav[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every flop samples pre-edge values; the
            // later indexed gate assignments simply override the cleared defaults.
            r_sync     <= {r_sync[SYNC_STAGES-2:0], wr_strobe};
            r_edge     <= r_sync[SYNC_STAGES-1];
            r_wr_event <= w_commit;
            r_gate_on  <= '0;
            r_gate_off <= '0;
            if (w_commit) begin
                if (wr_voice != FILTER_VOICE) begin
                    case (wr_addr)
                        3'd0: r_freq[wr_voice][7:0]  <= wr_data;
                        3'd1: r_freq[wr_voice][15:8] <= wr_data;
                        3'd2: r_pw[wr_voice][7:0]    <= wr_data;
                        3'd3: r_pw[wr_voice][11:8]   <= wr_data[3:0];
                        3'd4: r_atk[wr_voice]        <= wr_data;
                        3'd5: r_sus[wr_voice]        <= wr_data;
                        3'd6: begin
                            r_wav[wr_voice]      <= wr_data;
                            r_gate_on[wr_voice]  <= wr_data[0] & ~r_wav[wr_voice][0];
                            r_gate_off[wr_voice] <= ~wr_data[0] & r_wav[wr_voice][0];
                        end
                        default: ;
                    endcase
                end else begin
                    case (wr_addr)
                        3'd0: r_fc[2:0]  <= wr_data[2:0];
                        3'd1: r_fc[10:3] <= wr_data;
                        3'd2: r_res_filt <= wr_data;
                        3'd3: r_mode_vol <= wr_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign freq     = {r_freq[2], r_freq[1], r_freq[0]};
    assign pw       = {r_pw[2], r_pw[1], r_pw[0]};
    assign atk      = {r_atk[2], r_atk[1], r_atk[0]};
    assign sus      = {r_sus[2], r_sus[1], r_sus[0]};
    assign wav      = {r_wav[2], r_wav[1], r_wav[0]};
    assign fc       = r_fc;
    assign res_filt = r_res_filt;
    assign mode_vol = r_mode_vol;
    assign wr_event = r_wr_event;
    assign gate_on  = r_gate_on;
    assign gate_off = r_gate_off;

endmodule

// File: tb/tb_sid_reg_if.sv
// Scoreboard bench for sid_reg_if: the driver queues the expected register image per
// write, and a monitor compares it whenever wr_event fires.
module tb_sid_reg_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_strobe;
    logic [1:0]  wr_voice;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] atk, sus, wav;
    logic [10:0] fc;
    logic [7:0]  res_filt, mode_vol;
    logic        wr_event;
    logic [2:0]  gate_on, gate_off;

    sid_reg_if #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .wr_strobe(wr_strobe), .wr_voice(wr_voice),
        .wr_addr(wr_addr), .wr_data(wr_data), .freq(freq), .pw(pw), .atk(atk),
        .sus(sus), .wav(wav), .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
        .wr_event(wr_event), .gate_on(gate_on), .gate_off(gate_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] freq;
        logic [35:0] pw;
        logic [23:0] atk, sus, wav;
        logic [10:0] fc;
        logic [7:0]  res_filt, mode_vol;
        logic [2:0]  gon, goff;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // expected register image, updated field by field as writes are issued
    logic [47:0] m_freq;
    logic [35:0] m_pw;
    logic [23:0] m_atk, m_sus, m_wav;
    logic [10:0] m_fc;
    logic [7:0]  m_res, m_mode;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_freq = '0; m_pw = '0; m_atk = '0; m_sus = '0; m_wav = '0;
        m_fc = '0; m_res = '0; m_mode = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_freq"}, freq, 0);
        check({tag, "_pw"}, pw, 0);
        check({tag, "_regs"}, {atk, sus, wav}, 0);
        check({tag, "_filt"}, {fc, res_filt, mode_vol}, 0);
        check({tag, "_events"}, {wr_event, gate_on, gate_off}, 0);
    endtask

    // Host write: data set 1 clk ahead, strobe high for `high` clk, low 2 clk.
    task automatic host_write(input int v, input int a, input logic [7:0] d,
                              input logic [2:0] gon, input logic [2:0] goff, input int high);
        exp_t e;
        @(posedge clk); #1;
        wr_voice = 2'(v); wr_addr = 3'(a); wr_data = d;
        @(posedge clk); #1;
        wr_strobe = 1'b1;
        if (v < 3) begin
            case (a)
                0: m_freq[v*16 +: 8]    = d;
                1: m_freq[v*16+8 +: 8]  = d;
                2: m_pw[v*12 +: 8]      = d;
                3: m_pw[v*12+8 +: 4]    = d[3:0];
                4: m_atk[v*8 +: 8]      = d;
                5: m_sus[v*8 +: 8]      = d;
                6: m_wav[v*8 +: 8]      = d;
                default: ;
            endcase
        end else begin
            case (a)
                0: m_fc[2:0]  = d[2:0];
                1: m_fc[10:3] = d;
                2: m_res      = d;
                3: m_mode     = d;
                default: ;
            endcase
        end
        e.freq = m_freq; e.pw = m_pw; e.atk = m_atk; e.sus = m_sus; e.wav = m_wav;
        e.fc = m_fc; e.res_filt = m_res; e.mode_vol = m_mode;
        e.gon = gon; e.goff = goff; e.cyc = cyc + 3;
        exp_q.push_back(e);
        repeat (high) @(posedge clk);
        #1 wr_strobe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        check({tag, "_pending_events"}, exp_q.size(), 0);
    endtask

    // Monitor: compares the register image whenever the DUT reports a write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (wr_event === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_latency", cyc, e.cyc);
                    check("ev_freq", freq, e.freq);
                    check("ev_pw", pw, e.pw);
                    check("ev_atk", atk, e.atk);
                    check("ev_sus", sus, e.sus);
                    check("ev_wav", wav, e.wav);
                    check("ev_filt", {fc, res_filt, mode_vol}, {e.fc, e.res_filt, e.mode_vol});
                    check("ev_gate_on", gate_on, e.gon);
                    check("ev_gate_off", gate_off, e.goff);
                end
            end else if ((gate_on | gate_off) !== 3'b000) begin
                check("stray_gate_pulse", {gate_on, gate_off}, 0);
            end
        end
    end

    initial begin
        rst = 1'b1; wr_strobe = 1'b0; wr_voice = '0; wr_addr = '0; wr_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        host_write(0, 0, 8'h09, 3'b000, 3'b000, 2);
        host_write(0, 1, 8'h00, 3'b000, 3'b000, 2);
        drain("freq");
        check("freq_v0", freq[15:0], 16'h0009);

        host_write(0, 3, 8'hF8, 3'b000, 3'b000, 2);
        host_write(3, 0, 8'hFF, 3'b000, 3'b000, 2);
        host_write(3, 1, 8'hA5, 3'b000, 3'b000, 2);
        host_write(3, 3, 8'h1F, 3'b000, 3'b000, 2);
        drain("filt");
        check("pw_v0", pw[11:0], 12'h800);
        check("fc", fc, 11'h52F);
        check("mode_vol", mode_vol, 8'h1F);

        host_write(1, 6, 8'h21, 3'b010, 3'b000, 2);
        host_write(1, 6, 8'h21, 3'b000, 3'b000, 2);
        host_write(1, 6, 8'h20, 3'b000, 3'b010, 2);
        host_write(2, 4, 8'h33, 3'b000, 3'b000, 50);
        drain("gate_long");
        check("atk_all", atk, 24'h330000);

        host_write(0, 7, 8'hAA, 3'b000, 3'b000, 2);
        host_write(3, 5, 8'hBB, 3'b000, 3'b000, 2);
        drain("ignored");

        // strobe already high while reset releases
        @(posedge clk); #1;
        rst = 1'b1; wr_voice = 2'd0; wr_addr = 3'd0; wr_data = 8'h55; wr_strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        repeat (6) @(posedge clk);
        #1 wr_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all_zero("strobe_across_reset");

        // reset one cycle after the strobe rises cancels the pending write
        host_write(1, 2, 8'h66, 3'b000, 3'b000, 2);
        drain("pre_cancel");
        @(posedge clk); #1;
        wr_voice = 2'd0; wr_addr = 3'd0; wr_data = 8'h77;
        @(posedge clk); #1 wr_strobe = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        check_all_zero("mid_write_reset");
        repeat (4) @(posedge clk);
        #1 wr_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all_zero("after_cancel");

        host_write(2, 6, 8'h41, 3'b100, 3'b000, 2);
        drain("final");
        check("wav_v2", wav[23:16], 8'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
